// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl
//   Walks the hash core through one block. Starting at start_nonce, it offers one
//   nonce per cycle up to and including end_nonce. It counts the nonces in flight,
//   pairs the in-order results with their nonces and reports the winning ones.
//
//   Optional build macro: STOP_ON_FIRST_EN
//     defined   - the first success ends issuing, as an abort would. The drain that
//                 follows still pulses done. Any later success is not reported.
//     undefined - the whole range is swept and every success is reported.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-low reset
//   start                 begin a sweep; sampled only while idle
//   start_nonce/end_nonce inclusive nonce range, sampled with start
//   abort                 cancel the sweep in progress
//   core_ready            core accepts an issue this cycle
//   issue_valid/_nonce    nonce offered to the core (transfer on valid && ready)
//   issue_new_block       marks the first issue of a sweep
//   res_valid/res_success in-order result from the core
//   found_valid/_nonce    one-cycle pulse with the winning nonce
//   busy                  controller not idle
//   done                  one-cycle pulse: sweep completed and drained, not aborted
//   err                   sticky: result arrived with nothing in flight
module nonce_sweep_ctrl #(
  parameter int unsigned PIPE_DEPTH = 64,
  parameter int unsigned COUNTBITS  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_nonce,
  input  logic [31:0] end_nonce,
  input  logic        abort,
  input  logic        core_ready,
  output logic        issue_valid,
  output logic [31:0] issue_nonce,
  output logic        issue_new_block,
  input  logic        res_valid,
  input  logic        res_success,
  output logic        found_valid,
  output logic [31:0] found_nonce,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [COUNTBITS:0] C_DEPTH = (COUNTBITS+1)'(PIPE_DEPTH);
  localparam logic [COUNTBITS:0] C_ONE   = (COUNTBITS+1)'(1);

  logic [1:0]         r_state;
  logic [32:0]        r_remaining;
  logic [31:0]        r_issue_nonce;
  logic [31:0]        r_res_nonce;
  logic [COUNTBITS:0] r_inflight;
  logic               r_aborted;
  logic               r_new_block;
  logic               r_found_valid;
  logic [31:0]        r_found_nonce;
  logic               r_done;
  logic               r_err;

  logic w_active;
  logic w_abort;
  logic w_res_ok;
  logic w_hit;
  logic w_report;
  logic w_stop;
  logic w_issue_valid;
  logic w_xfer;
  logic w_last;

  assign w_active = (r_state != S_IDLE);
  assign w_abort  = abort && w_active;
  // A result only counts when something is in flight; otherwise it is an error.
  assign w_res_ok = res_valid && (r_inflight != '0);
  // Results that arrive after an abort, or in the abort cycle itself, are discarded.
  assign w_hit    = w_res_ok && res_success && !r_aborted && !w_abort;

`ifdef STOP_ON_FIRST_EN
  logic r_stopped;
  assign w_report = w_hit && !r_stopped;
  // The first hit during SWEEP stops issuing in the same cycle, as abort does.
  assign w_stop   = w_report && (r_state == S_SWEEP);
`else
  assign w_report = w_hit;
  assign w_stop   = 1'b0;
`endif

  assign w_issue_valid = (r_state == S_SWEEP) && (r_inflight < C_DEPTH) && !abort && !w_stop;
  assign w_xfer        = w_issue_valid && core_ready;
  assign w_last        = w_xfer && (r_remaining == 33'd1);

  assign issue_valid     = w_issue_valid;
  assign issue_nonce     = r_issue_nonce;
  assign issue_new_block = r_new_block && w_issue_valid;
  assign found_valid     = r_found_valid;
  assign found_nonce     = r_found_nonce;
  assign busy            = w_active;
  assign done            = r_done;
  assign err             = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_issue_nonce <= '0;
      r_res_nonce   <= '0;
      r_inflight    <= '0;
      r_aborted     <= 1'b0;
      r_new_block   <= 1'b0;
      r_found_valid <= 1'b0;
      r_found_nonce <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
`ifdef STOP_ON_FIRST_EN
      r_stopped     <= 1'b0;
`endif
    end else begin
      r_found_valid <= w_report;
      if (w_report) r_found_nonce <= r_res_nonce;
      r_done <= 1'b0;

      if (res_valid && (r_inflight == '0)) r_err <= 1'b1;

      // An issue and a result in the same cycle leave the count unchanged.
      case ({w_xfer, w_res_ok})
        2'b10:   r_inflight <= r_inflight + C_ONE;
        2'b01:   r_inflight <= r_inflight - C_ONE;
        default: r_inflight <= r_inflight;
      endcase

      if (w_res_ok) r_res_nonce <= r_res_nonce + 32'd1;

      if (w_xfer) begin
        r_issue_nonce <= r_issue_nonce + 32'd1;
        r_remaining   <= r_remaining - 33'd1;
        r_new_block   <= 1'b0;
      end

`ifdef STOP_ON_FIRST_EN
      if (w_report) r_stopped <= 1'b1;
`endif

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_SWEEP;
            r_issue_nonce <= start_nonce;
            r_res_nonce   <= start_nonce;
            // The count is held in 33 bits so that end == start-1 gives all 2^32 nonces.
            r_remaining   <= {1'b0, end_nonce - start_nonce} + 33'd1;
            r_aborted     <= 1'b0;
            r_new_block   <= 1'b1;
`ifdef STOP_ON_FIRST_EN
            r_stopped     <= 1'b0;
`endif
          end
        end
        S_SWEEP: begin
          if (w_abort) begin
            r_state   <= S_DRAIN;
            r_aborted <= 1'b1;
          end else if (w_last || w_stop) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_abort) r_aborted <= 1'b1;
          if (r_inflight == '0) begin
            r_state <= S_IDLE;
            r_done  <= !(r_aborted || w_abort);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Testbench for nonce_sweep_ctrl. It models the hash core with a fixed latency and
// random ready. The expected issue and winner sequences are built from the
// configured range alone.
module tb_nonce_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, core_ready, res_valid, res_success;
  logic [31:0] start_nonce, end_nonce;
  logic        issue_valid, issue_new_block, found_valid, busy, done, err;
  logic [31:0] issue_nonce, found_nonce;

  nonce_sweep_ctrl #(.PIPE_DEPTH(64), .COUNTBITS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .start_nonce(start_nonce), .end_nonce(end_nonce),
    .abort(abort), .core_ready(core_ready), .issue_valid(issue_valid), .issue_nonce(issue_nonce),
    .issue_new_block(issue_new_block), .res_valid(res_valid), .res_success(res_success),
    .found_valid(found_valid), .found_nonce(found_nonce), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] nonce;
    logic        win;
    int          due;
  } core_ent_t;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    int          lat;
    int          rdy;
    int          win_mode;
    logic [31:0] win_n;
    int          exp_cnt;
    int          hold;
  } vec_t;

  core_ent_t   core_q[$];
  logic [31:0] issued_q[$];
  logic [31:0] nb_q[$];
  logic [31:0] found_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        g_rst_n = 1'b0, g_start = 1'b0, g_abort = 1'b0, g_force_res = 1'b0, g_hold_res = 1'b0;
  logic [31:0] g_s = '0, g_e = '0, g_win_n = '0, g_salt = '0;
  int          g_lat = 1, g_rdy = 100, g_win_mode = 0;

  int          done_cnt, done_step, last_res_step, busy_done_bad, stall_bad;
  logic        last_iv = 1'b0, g_busy = 1'b0, stall_pend = 1'b0;
  logic [31:0] stall_nonce = '0;

  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_win(input logic [31:0] n);
    logic [31:0] h;
    case (g_win_mode)
      1: return n == g_win_n;
      2: begin
        h = (n ^ g_salt) * 32'h9E3779B1;
        return h[31:29] == 3'd0;
      end
      3: return (n == 32'h21) || (n == 32'h23);
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, then the next posedge commits.
  task automatic step();
    core_ent_t ent;
    @(negedge clk);
    rst = g_rst_n; start = g_start; start_nonce = g_s; end_nonce = g_e; abort = g_abort;
    core_ready = (int'($urandom_range(99)) < g_rdy);
    res_valid = 1'b0; res_success = 1'b0;
    if (g_force_res) res_valid = 1'b1;
    else if (!g_hold_res && core_q.size() > 0 && core_q[0].due <= cyc) begin
      res_valid = 1'b1;
      res_success = core_q[0].win;
    end
    #1;
    g_busy = busy;
    last_iv = issue_valid;
    if (found_valid) found_q.push_back(found_nonce);
    if (done) begin
      done_cnt++;
      done_step = cyc;
      if (busy) busy_done_bad++;
    end
    if (stall_pend && issue_valid && issue_nonce !== stall_nonce) stall_bad++;
    stall_pend = issue_valid && !core_ready;
    stall_nonce = issue_nonce;
    if (issue_valid && core_ready) begin
      ent.nonce = issue_nonce;
      ent.win = is_win(issue_nonce);
      ent.due = cyc + g_lat;
      core_q.push_back(ent);
      issued_q.push_back(issue_nonce);
      if (issue_new_block) nb_q.push_back(issue_nonce);
    end
    if (res_valid && !g_force_res) begin
      core_q.delete(0);
      last_res_step = cyc;
    end
    cyc++;
  endtask

  task automatic clear_obs();
    issued_q.delete(); nb_q.delete(); found_q.delete();
    done_cnt = 0; done_step = -100; last_res_step = -1; busy_done_bad = 0; stall_bad = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/issue_valid"}, issue_valid, 0);
    chk({tag, "/new_block"}, issue_new_block, 0);
    chk({tag, "/found_valid"}, found_valid, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/err"}, err, 0);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/issue_nonce"}, issue_nonce, 0);
    chk({tag, "/found_nonce"}, found_nonce, 0);
  endtask

  task automatic do_sweep(input vec_t v, input string tag, input bit inject_start);
    logic [31:0] exp_found[$];
    logic [31:0] nn, nb0, span;
    int          mism;
    bit          timeout;
    clear_obs();
    g_s = v.s; g_e = v.e; g_lat = v.lat; g_rdy = v.rdy;
    g_win_mode = v.win_mode; g_win_n = v.win_n; g_hold_res = (v.hold > 0);
    g_start = 1'b1; step(); g_start = 1'b0;
    timeout = 1'b1;
    for (int i = 1; i < 5000; i++) begin
      if (inject_start && i == 2) begin
        g_start = 1'b1; g_s = v.s + 32'h1000; g_e = v.s;
      end
      step();
      if (inject_start && i == 2) begin
        g_start = 1'b0; g_s = v.s; g_e = v.e;
      end
      if (v.hold > 0 && i == v.hold) begin
        chk({tag, "/pipe_full_cnt"}, issued_q.size(), 64);
        chk({tag, "/pipe_full_iv"}, last_iv, 0);
        g_hold_res = 1'b0;
      end
      if (!g_busy) begin
        timeout = 1'b0;
        break;
      end
    end
    step(); step();
    chk({tag, "/timeout"}, timeout, 0);

    // Reference: nonces s, s+1, ... (mod 2^32); winners are filtered from that list.
    span = v.e - v.s;
    exp_found.delete();
    for (longint k = 0; k <= longint'(span); k++) begin
      nn = v.s + 32'(k);
      if (is_win(nn)) begin
        exp_found.push_back(nn);
`ifdef STOP_ON_FIRST_EN
        break;
`endif
      end
    end
`ifdef STOP_ON_FIRST_EN
    if (exp_found.size() > 0) chk({tag, "/issue_cnt_le"}, issued_q.size() <= v.exp_cnt, 1);
    else chk({tag, "/issue_cnt"}, issued_q.size(), v.exp_cnt);
`else
    chk({tag, "/issue_cnt"}, issued_q.size(), v.exp_cnt);
`endif
    mism = 0;
    foreach (issued_q[j]) if (issued_q[j] !== v.s + 32'(j)) mism++;
    chk({tag, "/issue_seq_mism"}, mism, 0);
    nb0 = (nb_q.size() > 0) ? nb_q[0] : ~v.s;
    chk({tag, "/new_block_cnt"}, nb_q.size(), 1);
    chk({tag, "/new_block_nonce"}, nb0, v.s);
    chk({tag, "/found_cnt"}, found_q.size(), exp_found.size());
    mism = 0;
    foreach (found_q[j]) if (j >= exp_found.size() || found_q[j] !== exp_found[j]) mism++;
    chk({tag, "/found_mism"}, mism, 0);
    chk({tag, "/done_cnt"}, done_cnt, 1);
    chk({tag, "/done_lat"}, done_step - last_res_step, 2);
    chk({tag, "/busy_at_done"}, busy_done_bad, 0);
    chk({tag, "/stall_stable"}, stall_bad, 0);
    chk({tag, "/core_q_empty"}, core_q.size(), 0);
    chk({tag, "/err"}, err, 0);
  endtask

  initial begin
    vec_t v;
    int   len;
    bit   tmo;

    tbl[0] = '{s:32'h10, e:32'h13, lat:4, rdy:100, win_mode:0, win_n:32'h0, exp_cnt:4, hold:0};
    tbl[1] = '{s:32'h10, e:32'h13, lat:4, rdy:100, win_mode:1, win_n:32'h12, exp_cnt:4, hold:0};
    tbl[2] = '{s:32'hFFFFFFFE, e:32'h1, lat:3, rdy:100, win_mode:0, win_n:32'h0, exp_cnt:4, hold:0};
    tbl[3] = '{s:32'h0, e:32'd199, lat:2, rdy:100, win_mode:0, win_n:32'h0, exp_cnt:200, hold:80};
    tbl[4] = '{s:32'h500, e:32'h53F, lat:5, rdy:50, win_mode:2, win_n:32'h0, exp_cnt:64, hold:0};
    tbl[5] = '{s:32'h7, e:32'h7, lat:1, rdy:100, win_mode:0, win_n:32'h0, exp_cnt:1, hold:0};
    tbl[6] = '{s:32'h20, e:32'h2F, lat:4, rdy:100, win_mode:3, win_n:32'h0, exp_cnt:16, hold:0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; core_ready = 1'b0;
    res_valid = 1'b0; res_success = 1'b0; start_nonce = '0; end_nonce = '0;

    g_rst_n = 1'b0; step(); step();
    chk_reset("por");
    g_rst_n = 1'b1; step();

    for (int t = 0; t < 7; t++) do_sweep(tbl[t], $sformatf("vec%0d", t), (t % 2) == 1);

    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(150, 1));
      v.s = $urandom;
      v.e = v.s + 32'(len) - 32'd1;
      v.lat = int'($urandom_range(10, 1));
      v.rdy = int'($urandom_range(100, 30));
      v.win_mode = 2; v.win_n = '0; v.exp_cnt = len; v.hold = 0;
      g_salt = $urandom;
      do_sweep(v, $sformatf("rnd%0d", r), r[0]);
    end

    // Abort with five nonces in flight, one of which is a winner.
    clear_obs();
    g_s = 32'h100; g_e = 32'h1FF; g_lat = 6; g_rdy = 100; g_win_mode = 1; g_win_n = 32'h102;
    g_start = 1'b1; step(); g_start = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (issued_q.size() == 5) begin tmo = 1'b0; break; end
    end
    chk("abort/reach5_timeout", tmo, 0);
    g_abort = 1'b1; step(); g_abort = 1'b0;
    chk("abort/iv_same_cycle", last_iv, 0);
    tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!g_busy) begin tmo = 1'b0; break; end
    end
    step(); step();
    chk("abort/drain_timeout", tmo, 0);
    chk("abort/issue_cnt", issued_q.size(), 5);
    chk("abort/found_cnt", found_q.size(), 0);
    chk("abort/done_cnt", done_cnt, 0);
    chk("abort/core_q_empty", core_q.size(), 0);
    chk("abort/err", err, 0);

    // A result while idle sets err, which then stays set.
    g_force_res = 1'b1; step(); g_force_res = 1'b0; step();
    chk("idle_res/err_set", err, 1);
    step(); step(); step();
    chk("idle_res/err_sticky", err, 1);
    g_rst_n = 1'b0; step(); step();
    chk_reset("err_clr");
    g_rst_n = 1'b1; step();

    // Reset mid-sweep, after which the stale results set err.
    clear_obs();
    g_s = 32'h40; g_e = 32'h4F; g_lat = 8; g_rdy = 100; g_win_mode = 0;
    g_start = 1'b1; step(); g_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("midrst/issued_before", issued_q.size(), 6);
    g_rst_n = 1'b0; step(); step();
    chk_reset("midrst");
    g_rst_n = 1'b1;
    for (int i = 0; i < 40 && core_q.size() > 0; i++) step();
    step(); step();
    chk("midrst/stale_err", err, 1);
    chk("midrst/busy", busy, 0);
    g_rst_n = 1'b0; step(); step();
    chk_reset("final_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
